// File: rtl/write_full_ctrl.sv
// Write-side full/level tracking for an async FIFO: Gray write pointer, read-pointer synchronizer, pointer sanity check.
// Define ALMOST_FULL_EN to add the registered almost_full output (threshold AF_THRESH).
module write_full_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   w_ptr,
  input  logic [ADDR_W:0]   r_gray,
  output logic              full_flag,
  output logic [ADDR_W:0]   w_gray,
  output logic [ADDR_W:0]   w_level,
  output logic              ptr_err
`ifdef ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] r_gray_s;
  logic [ADDR_W:0] r_bin_s;
  logic [ADDR_W:0] w_ptr_q;
  logic [ADDR_W:0] ptr_step;
  logic            full_q;
  logic            chk_en;
  logic            bad_step;

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= r_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign r_gray_s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
    assign r_bin_s[i] = ^r_gray_s[ADDR_W:i];
  end

  // Same index with opposite wrap bit means the writer is a full lap ahead.
  assign full_flag = (w_ptr[ADDR_W] != r_bin_s[ADDR_W]) &&
                     (w_ptr[ADDR_W-1:0] == r_bin_s[ADDR_W-1:0]);
  assign w_level   = w_ptr - r_bin_s;

  assign ptr_step = w_ptr - w_ptr_q;
  assign bad_step = (ptr_step > ONE);

  // chk_en skips the first edge after reset so a stale w_ptr is not mistaken for a jump.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      w_gray  <= '0;
      w_ptr_q <= '0;
      full_q  <= 1'b0;
      chk_en  <= 1'b0;
      ptr_err <= 1'b0;
    end else begin
      w_gray  <= w_ptr ^ (w_ptr >> 1);
      w_ptr_q <= w_ptr;
      full_q  <= full_flag;
      chk_en  <= 1'b1;
      if (chk_en && (bad_step || (full_q && (w_ptr != w_ptr_q)))) begin
        ptr_err <= 1'b1;
      end
    end
  end

`ifdef ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (w_level >= AF_LVL);
    end
  end
`else
  // Threshold has no effect without almost_full; referenced only to keep the parameter list uniform.
  logic af_unused;
  assign af_unused = ^AF_THRESH;
`endif

endmodule

// File: tb/tb_write_full_ctrl.sv
// Randomized + directed bench for write_full_ctrl with a pointer-history reference model and scoreboard.
module tb_write_full_ctrl;

  localparam int AW    = 3;
  localparam int S     = 2;
  localparam int AF    = 6;
  localparam int MASK  = (1 << (AW + 1)) - 1;
  localparam int DEPTH = 1 << AW;

  logic          w_clk = 1'b0;
  logic          rst;
  logic [AW:0]   w_ptr;
  logic [AW:0]   r_gray;
  logic          full_flag;
  logic [AW:0]   w_gray;
  logic [AW:0]   w_level;
  logic          ptr_err;
`ifdef ALMOST_FULL_EN
  logic          almost_full;
`endif

  write_full_ctrl #(.ADDR_W(AW), .SYNC_STAGES(S), .AF_THRESH(AF)) dut (
    .w_clk     (w_clk),
    .rst       (rst),
    .w_ptr     (w_ptr),
    .r_gray    (r_gray),
    .full_flag (full_flag),
    .w_gray    (w_gray),
    .w_level   (w_level),
    .ptr_err   (ptr_err)
`ifdef ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    int wg;
    int lvl;
    int full;
    int err;
    int af;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: read pointers seen at each edge, writer history
  int   hist[$];
  bit   primed;
  int   prev_w;
  bit   prev_full;
  bit   m_err;
  bit   m_af;
  int   wr;
  int   rd;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic int gray2bin(input int g);
    for (int b = 0; b <= MASK; b++) begin
      if (gray(b) == (g & MASK)) return b;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(0);
    primed    = 1'b0;
    prev_w    = 0;
    prev_full = 1'b0;
    m_err     = 1'b0;
    m_af      = 1'b0;
  endtask

  // Drive one cycle's inputs (called just after a negedge) and predict the outputs after the next posedge.
  task automatic applyStimulus(input int wp, input int rg);
    int   sync_before;
    int   sync_after;
    int   lvl_edge;
    bit   full_edge;
    exp_t e;
    w_ptr  = wp[AW:0];
    r_gray = rg[AW:0];
    sync_before = hist[hist.size() - S];
    lvl_edge    = (wp - sync_before) & MASK;
    full_edge   = (lvl_edge == DEPTH);
    if (primed) begin
      if (((wp - prev_w) & MASK) > 1) m_err = 1'b1;
      if ((wp != prev_w) && prev_full) m_err = 1'b1;
    end
    primed    = 1'b1;
    prev_w    = wp;
    prev_full = full_edge;
    m_af      = (lvl_edge >= AF);
    hist.push_back(gray2bin(rg));
    if (hist.size() > 8) void'(hist.pop_front());
    sync_after = hist[hist.size() - S];
    e.lvl  = (wp - sync_after) & MASK;
    e.full = (e.lvl == DEPTH) ? 1 : 0;
    e.wg   = gray(wp);
    e.err  = m_err ? 1 : 0;
    e.af   = m_af ? 1 : 0;
    exp_q.push_back(e);
    @(negedge w_clk);
  endtask

  task automatic applyReset(input int wp);
    rst    = 1'b1;
    w_ptr  = wp[AW:0];
    r_gray = '0;
    repeat (2) @(negedge w_clk);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_ptr_err", 32'(ptr_err), 0);
    checkOutput("rst_w_gray", 32'(w_gray), 0);
    checkOutput("rst_full", 32'(full_flag), 0);
    checkOutput("rst_level", 32'(w_level), wp & MASK);
  endtask

  // Monitor: compare every predicted cycle shortly after the posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge w_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("w_gray", 32'(w_gray), e.wg);
        checkOutput("w_level", 32'(w_level), e.lvl);
        checkOutput("full_flag", 32'(full_flag), e.full);
        checkOutput("ptr_err", 32'(ptr_err), e.err);
`ifdef ALMOST_FULL_EN
        checkOutput("almost_full", 32'(almost_full), e.af);
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nw;
    rst    = 1'b1;
    w_ptr  = '0;
    r_gray = '0;
    modelReset();
    #1;
    checkOutput("init_w_gray", 32'(w_gray), 0);
    checkOutput("init_ptr_err", 32'(ptr_err), 0);
    @(negedge w_clk);

    // fill from empty to full, then release one slot
    applyReset(0);
    for (int w = 0; w <= DEPTH; w++) applyStimulus(w, 0);
    repeat (2) applyStimulus(DEPTH, 0);
    repeat (3) applyStimulus(DEPTH, gray(1));

    // wrap: read pointer at all-ones, writer wraps through zero and jumps
    applyReset(15);
    repeat (3) applyStimulus(15, gray(15));
    applyStimulus(0, gray(15));
    applyStimulus(7, gray(15));
    applyStimulus(7, gray(15));

    // illegal jump 2 -> 5 is sticky
    applyReset(0);
    for (int w = 0; w <= 2; w++) applyStimulus(w, 0);
    repeat (4) applyStimulus(5, 0);

    // asynchronous reset mid-cycle at level 5, writer left at 5
    applyReset(0);
    for (int w = 0; w <= 5; w++) applyStimulus(w, 0);
    @(posedge w_clk);
    #3;
    checkOutput("pre_async_level", 32'(w_level), 5);
    rst = 1'b1;
    #1;
    checkOutput("async_w_gray", 32'(w_gray), 0);
    checkOutput("async_ptr_err", 32'(ptr_err), 0);
    checkOutput("async_level", 32'(w_level), 5);
`ifdef ALMOST_FULL_EN
    checkOutput("async_af", 32'(almost_full), 0);
`endif
    applyReset(5);
    repeat (3) applyStimulus(5, 0);

    // randomized legal traffic with rare pointer glitches
    applyReset(0);
    wr = 0;
    rd = 0;
    for (int c = 0; c < 600; c++) begin
      nw = (!prev_full && ($urandom_range(0, 3) != 0)) ? ((wr + 1) & MASK) : wr;
      if ((((wr - rd) & MASK) != 0) && ($urandom_range(0, 2) == 0)) rd = (rd + 1) & MASK;
      if ($urandom_range(0, 299) == 0) nw = int'($urandom_range(0, MASK));
      wr = nw;
      applyStimulus(wr, gray(rd));
      if (m_err && ($urandom_range(0, 9) == 0)) begin
        applyReset(wr);
        rd = 0;
      end
    end

    repeat (3) @(negedge w_clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_full_ctrl.md
WRITE_FULL_CTRL -- requirements
Module: write_full_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 3, FIFO address width; depth = 2^ADDR_W, pointers are ADDR_W+1 bits.
REQ-002 Parameter: SYNC_STAGES, default 2, minimum 2, flop count of the read-pointer synchronizer.
REQ-003 Parameter: AF_THRESH, default 6, almost-full level threshold (used only with ALMOST_FULL_EN).
REQ-004 w_clk  input  1  write-domain clock; single clock for the whole block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 w_ptr  input  ADDR_W+1  binary write pointer from the write-pointer counter.
REQ-007 r_gray  input  ADDR_W+1  Gray-coded read pointer, launched from the read clock domain.
REQ-008 full_flag  output  1  FIFO full; gates the write-pointer counter.
REQ-009 w_gray  output  ADDR_W+1  registered Gray-coded write pointer, sent to the read domain.
REQ-010 w_level  output  ADDR_W+1  write-side fill level, 0..2^ADDR_W.
REQ-011 ptr_err  output  1  sticky error: illegal w_ptr step detected.
REQ-012 almost_full  output  1  registered level >= AF_THRESH (only with ALMOST_FULL_EN).

Function
REQ-013 w_gray SHALL register (w_ptr >> 1) ^ w_ptr every w_clk edge; latency 1 cycle, no combinational path from w_ptr.
REQ-014 r_gray SHALL pass through a SYNC_STAGES-deep flop chain on w_clk; the last stage is r_gray_s; no logic between stages.
REQ-015 r_gray_s SHALL be converted to binary r_bin_s by prefix XOR from the MSB down.
REQ-016 full_flag SHALL be combinational: 1 iff w_ptr[ADDR_W] != r_bin_s[ADDR_W] and w_ptr[ADDR_W-1:0] == r_bin_s[ADDR_W-1:0].
REQ-017 full_flag SHALL depend only on the w_ptr input and registered r_gray_s; it SHALL NOT depend on r_gray directly.
REQ-018 w_level SHALL be combinational (w_ptr - r_bin_s) modulo 2^(ADDR_W+1); equals 2^ADDR_W exactly when full_flag = 1.
REQ-019 Pointer wrap (all-ones to zero) SHALL be handled by modulo arithmetic with no special case; the MSB toggle distinguishes full from empty.
REQ-020 A w_ptr_q register SHALL hold the previous w_ptr; ptr_err SHALL set when w_ptr - w_ptr_q (modulo) is neither 0 nor 1, or when w_ptr changes while the previous cycle's full_flag was 1.
REQ-021 ptr_err SHALL remain set until reset.
REQ-022 A read-pointer advance SHALL reach full_flag/w_level exactly SYNC_STAGES w_clk edges after r_gray changes (pessimistic full; never falsely not-full).
REQ-023 Simultaneous w_ptr increment and r_gray_s update in one cycle SHALL yield level = old level + 1 - read advance, with no extra state.

Reset
REQ-024 On rst = 1, all sync stages, w_gray, w_ptr_q, ptr_err and almost_full SHALL clear to 0 immediately, regardless of w_clk.
REQ-025 After reset with w_ptr = 0: full_flag = 0, w_level = 0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight synchronized pointer; the first post-reset cycle SHALL NOT flag ptr_err.

Configuration
REQ-027 Macro ALMOST_FULL_EN defined: almost_full port and register exist; almost_full <= (w_level >= AF_THRESH) each w_clk edge, 1-cycle latency.
REQ-028 Macro ALMOST_FULL_EN undefined: almost_full port and logic SHALL be absent; AF_THRESH is ignored; all other behaviour identical.

Verification (ADDR_W=3, SYNC_STAGES=2, AF_THRESH=6)
REQ-029 Reset, r_gray=0, step w_ptr 0..8 one per cycle -> w_level 0..8; full_flag=1 only at w_ptr=8 (4'b1000); ptr_err=0.
REQ-030 Full at w_ptr=8, set r_gray=4'b0001 (bin 1) -> full_flag falls exactly 2 edges later; w_level = 7.
REQ-031 Wrap: r_bin=15, w_ptr steps 15 -> 0 -> 7 -> w_level 0,1,8; full_flag=1 at w_ptr=7 (bin 0111 vs 1111).
REQ-032 w_ptr jumps 2 -> 5 -> ptr_err=1 next edge and stays 1 until rst pulse.
REQ-033 ALMOST_FULL_EN defined: w_level reaches 6 -> almost_full=1 one edge later; macro undefined -> port absent, elaboration clean.
REQ-034 rst pulsed asynchronously mid-cycle with w_level=5 -> w_gray, sync flops, almost_full = 0 before next edge; ptr_err stays 0.
